// File: rtl/soc_system_host_0_tick_sequencer_pkg.sv
// Shared types and constants for the host tick sequencer and its divider.
// No logic; latency and backpressure are defined by the modules that import it.
package soc_system_host_0_tick_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACK   = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam logic [1:0] REG_STATUS     = 2'd0;
    localparam logic [1:0] REG_CONTROL    = 2'd1;
    localparam logic [1:0] REG_DIVIDER    = 2'd2;
    localparam logic [1:0] REG_TICK_COUNT = 2'd3;

    localparam int STATUS_EVENT_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int CTRL_COUNT_EN_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT    = 1;

    localparam logic [2:0]  TMR_STATUS_ADDR_DEF  = 3'd0;
    localparam logic [2:0]  TMR_CONTROL_ADDR_DEF = 3'd1;
    localparam logic [15:0] CYCLE_TICKS_DEF      = 16'd10;
    localparam logic [15:0] TMR_ITO_ENABLE       = 16'h0001;
    localparam logic [15:0] TMR_ACK_DATA         = 16'h0000;

    // A divider of zero is treated as one so that every tick still produces an event.
    function automatic logic [15:0] eff_divider(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/soc_system_host_0_tick_divider.sv
// Divides counted timer ticks into cycle events; pulse/event registered at the tick edge.
// Latency: one clock from tick to cycle_pulse; no backpressure, every tick is consumed.
module soc_system_host_0_tick_divider
    import soc_system_host_0_tick_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [15:0] divider,
    input  logic        div_wr,
    input  logic        status_wr,
    output logic        cycle_pulse,
    output logic        cycle_event,
    output logic        overrun
);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic        pulse_q, pulse_d;
    logic        event_q, event_d;
    logic        overrun_q, overrun_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        pulse_d   = 1'b0;
        event_d   = event_q;
        overrun_d = overrun_q;
        if (status_wr) begin
            event_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // A DIVIDER write restarts the count and suppresses a coincident pulse.
        if (div_wr) begin
            div_cnt_d = 16'd0;
        end else if (tick) begin
            if (div_cnt_q >= eff_divider(divider) - 16'd1) begin
                div_cnt_d = 16'd0;
                pulse_d   = 1'b1;
                event_d   = 1'b1;
                if (event_q && !status_wr) begin
                    overrun_d = 1'b1;
                end
            end else begin
                div_cnt_d = div_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= 16'd0;
            pulse_q   <= 1'b0;
            event_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pulse_q   <= pulse_d;
            event_q   <= event_d;
            overrun_q <= overrun_d;
        end
    end

    assign cycle_pulse = pulse_q;
    assign cycle_event = event_q;
    assign overrun     = overrun_q;

endmodule

// File: rtl/soc_system_host_0_tick_sequencer.sv
// Acknowledges interval-timer interrupts, counts/divides ticks, host register slave.
// Latency: ack write 1 clock after irq, reads 1 clock; no backpressure or wait states.
module soc_system_host_0_tick_sequencer
    import soc_system_host_0_tick_sequencer_pkg::*;
#(
    parameter logic [15:0] CYCLE_TICKS      = CYCLE_TICKS_DEF,
    parameter logic [2:0]  TMR_STATUS_ADDR  = TMR_STATUS_ADDR_DEF,
    parameter logic [2:0]  TMR_CONTROL_ADDR = TMR_CONTROL_ADDR_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        timer_irq,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [15:0] s_writedata,
    output logic [15:0] s_readdata,
    output logic        cycle_pulse,
    output logic        irq
);

    state_t      state_q;
    logic        tmr_cs_q, tmr_wn_q;
    logic [2:0]  tmr_addr_q;
    logic [15:0] tmr_data_q;

    // Master outputs are registered alongside the state, so each write lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            tmr_cs_q   <= 1'b0;
            tmr_wn_q   <= 1'b1;
            tmr_addr_q <= 3'd0;
            tmr_data_q <= 16'd0;
        end else begin
            tmr_cs_q   <= 1'b0;
            tmr_wn_q   <= 1'b1;
            tmr_addr_q <= 3'd0;
            tmr_data_q <= 16'd0;
            case (state_q)
                ST_INIT: begin
                    tmr_cs_q   <= 1'b1;
                    tmr_wn_q   <= 1'b0;
                    tmr_addr_q <= TMR_CONTROL_ADDR;
                    tmr_data_q <= TMR_ITO_ENABLE;
                    state_q    <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (timer_irq) begin
                        tmr_cs_q   <= 1'b1;
                        tmr_wn_q   <= 1'b0;
                        tmr_addr_q <= TMR_STATUS_ADDR;
                        tmr_data_q <= TMR_ACK_DATA;
                        state_q    <= ST_ACK;
                    end
                end
                ST_ACK:   state_q <= ST_GUARD;
                ST_GUARD: state_q <= ST_IDLE;
                default:  state_q <= ST_INIT;
            endcase
        end
    end

    logic        tick, counted_tick;
    logic        host_wr, host_rd;
    logic        status_wr, ctrl_wr, div_wr, tc_wr;
    logic        count_en_q, count_en_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] divider_q, divider_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cycle_event, overrun;

    assign tick         = (state_q == ST_IDLE) && timer_irq;
    assign counted_tick = tick && count_en_q;
    assign host_wr      = s_chipselect && !s_write_n;
    assign host_rd      = s_chipselect && s_write_n;

    always_comb begin
        status_wr  = host_wr && (s_address == REG_STATUS);
        ctrl_wr    = host_wr && (s_address == REG_CONTROL);
        div_wr     = host_wr && (s_address == REG_DIVIDER);
        tc_wr      = host_wr && (s_address == REG_TICK_COUNT);
        count_en_d = ctrl_wr ? s_writedata[CTRL_COUNT_EN_BIT] : count_en_q;
        irq_en_d   = ctrl_wr ? s_writedata[CTRL_IRQ_EN_BIT] : irq_en_q;
        divider_d  = div_wr ? s_writedata : divider_q;
        // A clear wins over a coincident increment.
        tick_cnt_d = tc_wr ? 16'd0 : (counted_tick ? tick_cnt_q + 16'd1 : tick_cnt_q);
        rdata_d    = 16'd0;
        if (host_rd) begin
            case (s_address)
                REG_STATUS: begin
                    rdata_d[STATUS_EVENT_BIT]   = cycle_event;
                    rdata_d[STATUS_OVERRUN_BIT] = overrun;
                end
                REG_CONTROL: begin
                    rdata_d[CTRL_COUNT_EN_BIT] = count_en_q;
                    rdata_d[CTRL_IRQ_EN_BIT]   = irq_en_q;
                end
                REG_DIVIDER:    rdata_d = divider_q;
                default:        rdata_d = tick_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_en_q <= 1'b1;
            irq_en_q   <= 1'b0;
            divider_q  <= CYCLE_TICKS;
            tick_cnt_q <= 16'd0;
            rdata_q    <= 16'd0;
        end else begin
            count_en_q <= count_en_d;
            irq_en_q   <= irq_en_d;
            divider_q  <= divider_d;
            tick_cnt_q <= tick_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    soc_system_host_0_tick_divider u_divider (
        .clk         (clk),
        .reset       (reset),
        .tick        (counted_tick),
        .divider     (divider_q),
        .div_wr      (div_wr),
        .status_wr   (status_wr),
        .cycle_pulse (cycle_pulse),
        .cycle_event (cycle_event),
        .overrun     (overrun)
    );

    assign tmr_address    = tmr_addr_q;
    assign tmr_chipselect = tmr_cs_q;
    assign tmr_write_n    = tmr_wn_q;
    assign tmr_writedata  = tmr_data_q;
    assign s_readdata     = rdata_q;
    assign irq            = cycle_event && irq_en_q;

endmodule
